// File: rtl/slow_clk_pkg.sv
// Shared defaults and per-channel status record for the multi-channel clock divider.
package slow_clk_pkg;

  localparam int unsigned CNT_W_DEF        = 27;
  localparam int unsigned DEFAULT_HALF_DEF = 50_000_000;

  typedef struct packed {
    logic clk_out;
    logic tick;
    logic pending;
  } ch_status_t;

endpackage

// File: rtl/slow_clk_ch.sv
// One divided-clock channel: half-period counter, staged reload and glitch-free apply.
module slow_clk_ch #(
  parameter int unsigned CNT_W        = 27,
  parameter int unsigned DEFAULT_HALF = 50_000_000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      half_q     <= CNT_W'(DEFAULT_HALF);
      pend_val_q <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      half_q     <= half_d;
      pend_val_q <= pend_val_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  // A staged value only lands on a falling wrap (or immediately when stopped),
  // so neither the high nor the low phase is ever shortened.
  always_comb begin
    half_d     = half_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    wrap       = (cnt_q == (half_q - CNT_W'(1)));

    if (half_q == '0) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pending_q) begin
        half_d    = pend_val_q;
        pending_d = 1'b0;
      end
    end else if (wrap) begin
      cnt_d  = '0;
      clk_d  = !clk_q;
      tick_d = !clk_q;
      if (clk_q && pending_q) begin
        half_d    = pend_val_q;
        pending_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // wr is only possible while not pending, so it never collides with an apply.
    if (wr) begin
      pend_val_d = wr_half;
      pending_d  = 1'b1;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: rtl/slow_clk_multi.sv
// NUM_CH independent programmable clock dividers sharing one configuration port.
module slow_clk_multi
  import slow_clk_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_chan,
  input  logic [CNT_W-1:0]          cfg_half,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         pending
);

  localparam int unsigned CHW = $clog2(NUM_CH);

  ch_status_t [NUM_CH-1:0] st;
  logic       [NUM_CH-1:0] wr;

  // Out-of-range channel indices are always ready and simply dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_chan == CHW'(i)) cfg_ready = !st[i].pending;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = cfg_valid && cfg_ready && (cfg_chan == CHW'(g));

    slow_clk_ch #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .wr      (wr[g]),
      .wr_half (cfg_half),
      .clk_out (st[g].clk_out),
      .tick    (st[g].tick),
      .pending (st[g].pending)
    );

    assign clk_out[g] = st[g].clk_out;
    assign tick[g]    = st[g].tick;
    assign pending[g] = st[g].pending;
  end

endmodule

// File: tb/tb_slow_clk_multi.sv
// Bench for slow_clk_multi: absolute-time toggle model plus directed timing anchors.
module tb_slow_clk_multi;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int DEF    = 5;

  logic             clk_in = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [0:0]       cfg_chan = '0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic [1:0]       clk_out, tick, pending;

  slow_clk_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_half  (cfg_half),
    .clk_out   (clk_out),
    .tick      (tick),
    .pending   (pending)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  // Model: each channel toggles at an absolute edge number m_next.
  int t = 0;
  int t_rst = 0;
  int m_half[NUM_CH];
  int m_pend[NUM_CH];
  bit m_pending[NUM_CH];
  bit m_level[NUM_CH];
  bit m_tick[NUM_CH];
  int m_next[NUM_CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d since reset)", name, act, exp, t - t_rst);
    end
  endtask

  function automatic bit exp_ready(input int ch);
    if (ch >= NUM_CH) return 1'b1;
    return !m_pending[ch];
  endfunction

  task automatic model_step(input bit r, input bit v, input int ch, input int h);
    bit acc;
    t++;
    if (!r) begin
      t_rst = t;
      for (int i = 0; i < NUM_CH; i++) begin
        m_half[i] = DEF; m_pend[i] = 0; m_pending[i] = 0;
        m_level[i] = 0;  m_tick[i] = 0; m_next[i] = t + DEF;
      end
      return;
    end
    acc = v && exp_ready(ch);
    for (int i = 0; i < NUM_CH; i++) begin
      m_tick[i] = 0;
      if (m_half[i] == 0) begin
        m_level[i] = 0;
        if (m_pending[i]) begin
          m_half[i] = m_pend[i]; m_pending[i] = 0; m_next[i] = t + m_half[i];
        end
      end else if (t == m_next[i]) begin
        m_level[i] = !m_level[i];
        m_tick[i]  = m_level[i];
        if (!m_level[i] && m_pending[i]) begin
          m_half[i] = m_pend[i]; m_pending[i] = 0;
        end
        m_next[i] = t + m_half[i];
      end
    end
    if (acc && ch < NUM_CH) begin
      m_pend[ch] = h; m_pending[ch] = 1;
    end
  endtask

  // One clock: drive at negedge, check ready, advance model at posedge, compare at negedge.
  task automatic step(input bit r, input bit v, input int ch, input int h);
    logic [1:0] ec, et, ep;
    rst_n = r; cfg_valid = v; cfg_chan = 1'(ch); cfg_half = CNT_W'(h);
    #1;
    if (started) chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready(ch)));
    @(posedge clk_in);
    model_step(r, v, ch, h);
    @(negedge clk_in);
    started = 1;
    for (int i = 0; i < NUM_CH; i++) begin
      ec[i] = m_level[i]; et[i] = m_tick[i]; ep[i] = m_pending[i];
    end
    chk("model clk_out", 32'(clk_out), 32'(ec));
    chk("model tick",    32'(tick),    32'(et));
    chk("model pending", 32'(pending), 32'(ep));
  endtask

  task automatic adv_to(input int n);
    while (t - t_rst < n) step(1, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk_in);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset clk_out", 32'(clk_out), 32'h0);
    chk("reset pending", 32'(pending), 32'h0);

    adv_to(4);  chk("pre-rise clk_out", 32'(clk_out), 32'h0);
    adv_to(5);  chk("first rise clk_out", 32'(clk_out), 32'h3);
                chk("first rise tick", 32'(tick), 32'h3);
    adv_to(6);  chk("tick one cycle", 32'(tick), 32'h0);

    step(1, 1, 1, 2);                       // edge 7: stage half=2 on ch1
    chk("ch1 pending", 32'(pending), 32'h2);
    step(1, 1, 1, 2);  chk("blocked ready 8", 32'(cfg_ready), 32'h0);
    step(1, 1, 1, 2);  chk("blocked ready 9", 32'(cfg_ready), 32'h0);
    step(1, 1, 1, 2);                       // edge 10: apply
    chk("apply clk_out", 32'(clk_out), 32'h0);
    chk("apply pending", 32'(pending), 32'h0);
    step(1, 1, 1, 2);                       // edge 11: second write accepted
    chk("re-stage pending", 32'(pending), 32'h2);
    step(1, 0, 0, 0);                       // edge 12
    chk("ch1 rise 12", 32'(clk_out), 32'h2);
    chk("ch1 tick 12", 32'(tick), 32'h2);
    adv_to(14); chk("ch1 fall 14", 32'(clk_out), 32'h0);
    adv_to(15); chk("ch0 rise 15", 32'(clk_out), 32'h1);
    adv_to(16); chk("both high 16", 32'(clk_out), 32'h3);

    step(1, 1, 0, 0);                       // edge 17: stop ch0
    adv_to(20); chk("ch0 stopped 20", 32'(clk_out), 32'h2);
                chk("stop pending", 32'(pending), 32'h0);
    adv_to(29); chk("ch0 still low", 32'(clk_out[0]), 32'h0);

    step(1, 1, 0, 3);                       // edge 30: restart ch0 with half=3
    chk("stopped pending", 32'(pending[0]), 32'h1);
    step(1, 0, 0, 0);
    chk("stopped apply", 32'(pending[0]), 32'h0);
    adv_to(33); chk("ch0 low 33", 32'(clk_out[0]), 32'h0);
    adv_to(34); chk("ch0 rise 34", 32'(clk_out[0]), 32'h1);
                chk("ch0 tick 34", 32'(tick[0]), 32'h1);
    adv_to(37); chk("ch0 fall 37", 32'(clk_out[0]), 32'h0);
    adv_to(40); chk("ch0 rise 40", 32'(clk_out[0]), 32'h1);

    step(1, 1, 0, 4);                       // edge 41: stage while high
    chk("pre-reset pending", 32'(pending[0]), 32'h1);
    step(0, 0, 0, 0);                       // single-cycle reset
    chk("mid reset clk_out", 32'(clk_out), 32'h0);
    chk("mid reset pending", 32'(pending), 32'h0);
    adv_to(4);  chk("post reset low", 32'(clk_out), 32'h0);
    adv_to(5);  chk("post reset rise", 32'(clk_out), 32'h3);

    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slow_clk_multi.md
SLOW_CLK_MULTI -- requirements
Module: slow_clk_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divided-clock channels (SHALL be >= 2).
REQ-002 Parameter CNT_W, default 27, width of each channel's half-period counter and register.
REQ-003 Parameter DEFAULT_HALF, default 50_000_000, half-period loaded into every channel at reset (1 Hz from 100 MHz).
REQ-004 Port clk_in, input, 1, sole clock; the block SHALL have one clock.
REQ-005 Port rst_n, input, 1, reset; the block SHALL use a synchronous, active-low reset.
REQ-006 Port cfg_valid, input, 1, configuration write request.
REQ-007 Port cfg_ready, output, 1, write accepted on a clk_in edge where cfg_valid && cfg_ready.
REQ-008 Port cfg_chan, input, $clog2(NUM_CH), target channel index.
REQ-009 Port cfg_half, input, CNT_W, new half-period in clk_in cycles; 0 means stop.
REQ-010 Port clk_out, output, NUM_CH, registered divided clock per channel.
REQ-011 Port tick, output, NUM_CH, one-cycle pulse per channel, coincident with each clk_out rise.
REQ-012 Port pending, output, NUM_CH, per-channel flag: a staged half-period is awaiting application.

Function
REQ-013 Each channel SHALL hold half (active), pend_val, pending, cnt (CNT_W), and clk_out.
REQ-014 Running (half != 0): on wrap (cnt == half-1), cnt SHALL return to 0 and clk_out SHALL toggle; otherwise cnt SHALL increment by 1.
REQ-015 Output period SHALL be 2*half clk_in cycles, 50% duty; half = 1 gives period 2.
REQ-016 tick[i] SHALL be 1 only in the cycle where clk_out[i] has just become 1.
REQ-017 Stopped (half == 0): cnt SHALL stay 0, clk_out SHALL stay 0, tick SHALL stay 0.
REQ-018 cfg_ready SHALL equal !pending[cfg_chan], derived from registered state only.
REQ-019 On an accepted write, pend_val SHALL load cfg_half and pending SHALL set on the next edge.
REQ-020 A running channel SHALL apply pend_val only on a wrap where clk_out goes 1->0: half takes pend_val, cnt becomes 0, pending clears.
REQ-021 A stopped channel SHALL apply pend_val on the first edge after pending is set; cnt becomes 0 and clk_out stays 0.
REQ-022 Updates SHALL NOT produce a clk_out pulse shorter than min(old half, new half) cycles.
REQ-023 Writing 0 to a running channel SHALL stop it low at the next falling transition.
REQ-024 A write with cfg_chan >= NUM_CH SHALL be accepted and ignored.
REQ-025 Channels SHALL be fully independent; a write to one channel SHALL NOT disturb the others.

Reset
REQ-026 While rst_n is sampled low: cnt = 0, clk_out = 0, tick = 0, pending = 0, pend_val = 0, half = DEFAULT_HALF for all channels.
REQ-027 Reset asserted mid-period SHALL discard in-flight counts and staged writes with no residual pulse.
REQ-028 After rst_n is sampled high, clk_out[i] SHALL first rise DEFAULT_HALF cycles later.

Structure
REQ-029 Package slow_clk_pkg SHALL hold the CNT_W and DEFAULT_HALF defaults and the per-channel state record typedef.
REQ-030 Sub-module slow_clk_ch SHALL implement one channel (counter, staging, apply logic); the top SHALL instantiate NUM_CH copies and decode cfg_chan.
REQ-031 The RTL SHALL NOT use clk_out as a clock anywhere inside the block.

Verification (NUM_CH=2, CNT_W=8, DEFAULT_HALF=5)
REQ-032 Reset release, no writes -> clk_out[0] and clk_out[1] rise at cycles 5, 15, 25 and fall at 10, 20; tick pulses at cycles 5 and 15.
REQ-033 Write ch1 half=2 at cycle 7 (clk_out high) -> pending[1]=1 and cfg_ready=0 for ch1; applied at falling edge cycle 10; rises at 12, 16; falls at 14.
REQ-034 Second write to ch1 while pending -> cfg_ready=0 and pend_val unchanged; the write is accepted in the cycle after the apply.
REQ-035 Write ch0 half=0 -> ch0 stops low at its next falling transition; tick[0] stays 0; ch1 timing is unchanged.
REQ-036 Write stopped ch0 half=3 -> applied on the next edge; first rise 3 cycles after the apply; period 6.
REQ-037 rst_n low for one cycle while clk_out=1 and pending=1 -> next edge: all outputs 0, pending 0; first rise is 5 cycles after release.
